i_buf_ds_deser: RTL and testbench



---
 rtl/i_buf_ds_deser.sv | 195 +++++++++++++++++++
 tb/tb_i_buf_ds_deser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_buf_ds_deser.sv
// i_buf_ds_deser
// Differential input receiver followed by a serial-to-parallel deserializer
// with bitslip-based word alignment.
//
// Parameters
//   WIDTH        word width, 3..10
//   WEAK_KEEPER  failsafe level for an invalid pair: "NONE", "PULLUP", "PULLDOWN"
//   FAULT_CYCLES consecutive invalid samples before FAULT asserts, 1..255
//
// Ports
//   CLK          bit clock, one serial bit per rising edge
//   RST          asynchronous active-low reset
//   I_P, I_N     differential pair legs
//   EN           receiver/deserializer enable
//   BITSLIP_ADJ  level input, each rising edge requests a one-bit frame shift
//   O            resolved single-ended bit, registered
//   Q            deserialized word, first-received bit in Q[WIDTH-1]
//   DATA_VALID   one-cycle pulse when Q is updated
//   FAULT        pair invalid for at least FAULT_CYCLES consecutive samples
//   fsm_state    debug view of the bitslip FSM state
//
// Handshake: Q/DATA_VALID is a valid-only interface. DATA_VALID is high for
// exactly one cycle per word, there is no ready/backpressure, and Q holds its
// value until the next word is assembled.
module i_buf_ds_deser #(
    parameter int    WIDTH        = 4,
    parameter string WEAK_KEEPER  = "NONE",
    parameter int    FAULT_CYCLES = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_P,
    input  logic             I_N,
    input  logic             EN,
    input  logic             BITSLIP_ADJ,
    output logic             O,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             FAULT,
    output logic [1:0]       fsm_state
);

    generate
        if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
            $error("i_buf_ds_deser: WIDTH must be 3..10");
        end
        if (!(WEAK_KEEPER == "NONE" || WEAK_KEEPER == "PULLUP" ||
              WEAK_KEEPER == "PULLDOWN")) begin : g_bad_keeper
            $error("i_buf_ds_deser: WEAK_KEEPER must be NONE, PULLUP or PULLDOWN");
        end
        if (FAULT_CYCLES < 1 || FAULT_CYCLES > 255) begin : g_bad_fault
            $error("i_buf_ds_deser: FAULT_CYCLES must be 1..255");
        end
    endgenerate

    localparam int         CW            = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [7:0] FAULT_MAX     = 8'(FAULT_CYCLES);
    localparam logic       KEEP_PULLUP   = (WEAK_KEEPER == "PULLUP");
    localparam logic       KEEP_PULLDOWN = (WEAK_KEEPER == "PULLDOWN");

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SLIP    = 2'd1,
        LOCKOUT = 2'd2
    } slip_state_t;

    slip_state_t      state;
    logic             lock_cnt;
    logic             adj_q;
    logic             adj_rise;
    logic             pair_valid;
    logic             rx_bit;
    logic             last_valid;
    logic [7:0]       fault_cnt;
    logic [CW-1:0]    cnt;
    // Only WIDTH-1 history bits are needed: the newest bit comes straight
    // from rx_bit when a word is captured.
    logic [WIDTH-2:0] shift;

    // Pair resolve. The case statement matches 4-state values exactly, so X
    // or Z on either leg falls into the invalid (default) branch.
    always_comb begin
        pair_valid = 1'b0;
        rx_bit     = last_valid;
        case ({I_P, I_N})
            2'b10: begin
                pair_valid = 1'b1;
                rx_bit     = 1'b1;
            end
            2'b01: begin
                pair_valid = 1'b1;
                rx_bit     = 1'b0;
            end
            default: begin
                if (KEEP_PULLUP) begin
                    rx_bit = 1'b1;
                end else if (KEEP_PULLDOWN) begin
                    rx_bit = 1'b0;
                end else begin
                    rx_bit = last_valid;
                end
            end
        endcase
    end

    assign adj_rise  = BITSLIP_ADJ & ~adj_q;
    assign FAULT     = (fault_cnt == FAULT_MAX);
    assign fsm_state = state;

    // Receiver path and fault monitor: run regardless of EN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            O          <= 1'b0;
            last_valid <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            O <= rx_bit;
            if (pair_valid) begin
                last_valid <= rx_bit;
                fault_cnt  <= 8'd0;
            end else if (fault_cnt != FAULT_MAX) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

    // Bitslip FSM. A rise is accepted only in IDLE; SLIP lasts one cycle and
    // LOCKOUT two, during which further rises are dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            lock_cnt <= 1'b0;
            adj_q    <= 1'b0;
        end else begin
            adj_q <= BITSLIP_ADJ;
            if (!EN) begin
                state    <= IDLE;
                lock_cnt <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (adj_rise) begin
                            state <= SLIP;
                        end
                    end
                    SLIP: begin
                        state    <= LOCKOUT;
                        lock_cnt <= 1'b0;
                    end
                    LOCKOUT: begin
                        if (lock_cnt) begin
                            state    <= IDLE;
                            lock_cnt <= 1'b0;
                        end else begin
                            lock_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        lock_cnt <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Deserializer. In SLIP the bit is still shifted in but cnt holds, which
    // pushes the word boundary one bit later; the hold also suppresses a word
    // that would otherwise complete on that edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt        <= '0;
            shift      <= '0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
        end else if (!EN) begin
            cnt        <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            shift <= {shift[WIDTH-3:0], rx_bit};
            if (state == SLIP) begin
                DATA_VALID <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                Q          <= {shift, rx_bit};
                DATA_VALID <= 1'b1;
                cnt        <= '0;
            end else begin
                cnt        <= cnt + CW'(1);
                DATA_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i_buf_ds_deser.sv
// Testbench for i_buf_ds_deser. Two instances share the stimulus:
//   dut_a: WIDTH=4, WEAK_KEEPER="NONE",   FAULT_CYCLES=8
//   dut_b: WIDTH=5, WEAK_KEEPER="PULLUP", FAULT_CYCLES=3
// A behavioural model counts received bits per word, tracks the accepted
// bitslip requests by edge number, and forms each word from the last WIDTH
// received bits.
module tb_i_buf_ds_deser;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic i_p = 1'b0;
  logic i_n = 1'b1;
  logic en = 1'b0;
  logic adj = 1'b0;

  logic       o_a, dv_a, fault_a;
  logic [3:0] q_a;
  logic [1:0] st_a;
  logic       o_b, dv_b, fault_b;
  logic [4:0] q_b;
  logic [1:0] st_b;

  i_buf_ds_deser #(.WIDTH(4), .WEAK_KEEPER("NONE"), .FAULT_CYCLES(8)) dut_a (
    .CLK(clk), .RST(rst_n), .I_P(i_p), .I_N(i_n), .EN(en), .BITSLIP_ADJ(adj),
    .O(o_a), .Q(q_a), .DATA_VALID(dv_a), .FAULT(fault_a), .fsm_state(st_a)
  );

  i_buf_ds_deser #(.WIDTH(5), .WEAK_KEEPER("PULLUP"), .FAULT_CYCLES(3)) dut_b (
    .CLK(clk), .RST(rst_n), .I_P(i_p), .I_N(i_n), .EN(en), .BITSLIP_ADJ(adj),
    .O(o_b), .Q(q_b), .DATA_VALID(dv_b), .FAULT(fault_b), .fsm_state(st_b)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  int cfg_w[2]    = '{4, 5};
  int cfg_fc[2]   = '{8, 3};
  int cfg_keep[2] = '{0, 1};  // 0: hold last valid, 1: pull up

  logic        m_last[2];
  int          m_fcnt[2];
  int          m_bits[2];
  int unsigned m_hist[2];
  int unsigned m_q[2];
  logic        m_o[2];
  logic        m_dv[2];
  int          edge_n;
  int          slip_at;
  int          next_ok;
  logic        adj_prev;

  // scoreboard of words expected from dut_a
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_last[c] = 1'b0;
      m_fcnt[c] = 0;
      m_bits[c] = 0;
      m_hist[c] = 0;
      m_q[c]    = 0;
      m_o[c]    = 1'b0;
      m_dv[c]   = 1'b0;
    end
    edge_n   = 0;
    slip_at  = -1;
    next_ok  = 0;
    adj_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic valid, b, hold, req;
    valid = (i_p === 1'b1 && i_n === 1'b0) || (i_p === 1'b0 && i_n === 1'b1);
    edge_n++;
    hold = en && (edge_n == slip_at);
    req  = en && adj && !adj_prev && (edge_n >= next_ok);
    for (int c = 0; c < 2; c++) begin
      if (valid) b = i_p;
      else if (cfg_keep[c] == 1) b = 1'b1;
      else b = m_last[c];
      if (valid) m_last[c] = i_p;
      m_o[c] = b;
      if (valid) m_fcnt[c] = 0;
      else if (m_fcnt[c] < cfg_fc[c]) m_fcnt[c]++;
      m_dv[c] = 1'b0;
      if (!en) begin
        m_bits[c] = 0;
      end else begin
        m_hist[c] = (m_hist[c] << 1) | 32'(b);
        if (!hold) begin
          m_bits[c]++;
          if (m_bits[c] == cfg_w[c]) begin
            m_bits[c] = 0;
            m_q[c]    = m_hist[c] & ((32'd1 << cfg_w[c]) - 32'd1);
            m_dv[c]   = 1'b1;
            if (c == 0) exp_q.push_back(4'(m_q[0]));
          end
        end
      end
    end
    if (!en) begin
      slip_at = -1;
      next_ok = 0;
    end else if (req) begin
      slip_at = edge_n + 1;
      next_ok = edge_n + 4;
    end
    adj_prev = adj;
  endtask

  task automatic check_outputs();
    check("o_a",     32'(o_a),     32'(m_o[0]));
    check("q_a",     32'(q_a),     m_q[0]);
    check("dv_a",    32'(dv_a),    32'(m_dv[0]));
    check("fault_a", 32'(fault_a), 32'(m_fcnt[0] == cfg_fc[0]));
    check("o_b",     32'(o_b),     32'(m_o[1]));
    check("q_b",     32'(q_b),     m_q[1]);
    check("dv_b",    32'(dv_b),    32'(m_dv[1]));
    check("fault_b", 32'(fault_b), 32'(m_fcnt[1] == cfg_fc[1]));
    if (dv_a === 1'b1) begin
      if (exp_q.size() > 0) check("sb_word_a", 32'(q_a), 32'(exp_q.pop_front()));
      else check("sb_extra_word_a", 32'(dv_a), 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a falling edge; outputs are sampled on the
  // following falling edge.
  task automatic step(input logic ip, input logic in, input logic e, input logic a);
    i_p = ip;
    i_n = in;
    en  = e;
    adj = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bit(input logic b);
    step(b, ~b, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adj   = 1'b0;
    #1;
    model_reset();
    check("rst_o_a",  32'(o_a), 32'd0);
    check("rst_q_a",  32'(q_a), 32'd0);
    check("rst_dv_a", 32'(dv_a), 32'd0);
    check("rst_q_b",  32'(q_b), 32'd0);
    check("rst_f_b",  32'(fault_b), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t1_bits = 8'b1011_0010;
  logic [3:0] t2_pat  = 4'b0110;
  logic [3:0] t4_bits = 4'b1110;
  logic [3:0] t5_bits = 4'b0101;
  int dv_cnt;

  initial begin
    @(negedge clk);

    // 1: two consecutive words
    do_reset();
    dv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(t1_bits[7 - i]);
      if (dv_a) dv_cnt++;
      if (i == 3) begin
        check("t1_word0", 32'(q_a), 32'b1011);
        check("t1_dv0", 32'(dv_a), 32'd1);
      end
      if (i == 7) check("t1_word1", 32'(q_a), 32'b0010);
    end
    check("t1_dv_count", 32'(dv_cnt), 32'd2);
    send_bit(1'b0);
    check("t1_dv_drop", 32'(dv_a), 32'd0);

    // 2: bitslip mid-word, second rise inside lockout is dropped
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step(t2_pat[3 - ((e - 1) % 4)], ~t2_pat[3 - ((e - 1) % 4)], 1'b1,
           (e == 6 || e == 8));
      if (e == 4)  check("t2_word_pre", 32'(q_a), 32'b0110);
      if (e == 8)  check("t2_no_word_e8", 32'(dv_a), 32'd0);
      if (e == 9)  begin
        check("t2_word_slip", 32'(q_a), 32'b1100);
        check("t2_dv_slip", 32'(dv_a), 32'd1);
      end
      if (e == 12) check("t2_no_word_e12", 32'(dv_a), 32'd0);
      if (e == 13) check("t2_dv_e13", 32'(dv_a), 32'd1);
      if (e == 17) check("t2_word_post", 32'(q_a), 32'b1100);
    end

    // 3: keeper behaviour and fault flag
    do_reset();
    send_bit(1'b1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("t3_o_none", 32'(o_a), 32'd1);
      check("t3_o_pullup", 32'(o_b), 32'd1);
      check("t3_fault_b", 32'(fault_b), 32'(i == 3));
    end
    check("t3_q_none", 32'(q_a), 32'b1111);
    check("t3_fault_a", 32'(fault_a), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_fault_clr", 32'(fault_b), 32'd0);
    check("t3_o_valid", 32'(o_b), 32'd0);

    // 4: reset mid-word (two bits of the next word already in)
    send_bit(1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_bit(t4_bits[3 - i]);
      check("t4_dv", 32'(dv_a), 32'(i == 3));
    end
    check("t4_word", 32'(q_a), 32'b1110);

    // 5: EN dropped mid-word
    do_reset();
    for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 3);
    check("t5_word0", 32'(q_a), 32'b1001);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_dv_off", 32'(dv_a), 32'd0);
      check("t5_q_hold", 32'(q_a), 32'b1001);
    end
    for (int i = 0; i < 4; i++) send_bit(t5_bits[3 - i]);
    check("t5_word1", 32'(q_a), 32'b0101);

    // 6: randomized traffic
    do_reset();
    begin
      int   burst = 0;
      logic b;
      logic e = 1'b1;
      logic a = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 499) == 0) do_reset();
        if ($urandom_range(0, 5) == 0) a = ~a;
        if ($urandom_range(0, 19) == 0) e = ~e;
        else if (!e && $urandom_range(0, 2) == 0) e = 1'b1;
        if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(3, 12);
        if (burst > 0) begin
          burst--;
          b = 1'($urandom_range(0, 1));
          step(b, b, e, a);
        end else if ($urandom_range(0, 9) < 8) begin
          b = 1'($urandom_range(0, 1));
          step(b, ~b, e, a);
        end else begin
          b = 1'($urandom_range(0, 1));
          step(b, b, e, a);
        end
      end
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
